// File: rtl/rgbpwm_pkg.sv
// Shared types and constants for the RGB PWM capture block.
//   state_e      : capture FSM state (UNLOCKED, RUN)
//   ERR_*        : values reported on err_code alongside an err pulse
package rgbpwm_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    RUN      = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_SHORT     = 2'd1;
  localparam logic [1:0] ERR_MISSING   = 2'd2;
  localparam logic [1:0] ERR_MALFORMED = 2'd3;

endpackage

// File: rtl/pwm_chan_meter.sv
// Per-channel meter: counts high samples of one LED line over a PWM period and
// flags waveforms that cannot come from a `value > ramp` comparator.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   restart      : first cycle of a new period; this cycle's sample starts the count
//   led          : LED drive line sample
//   count        : high cycles seen since the last restart (saturating)
//   bad          : sticky malformed flag for the current period
module pwm_chan_meter
  import rgbpwm_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 led,
  output logic [PWM_WIDTH-1:0] count,
  output logic                 bad
);

  localparam logic [PWM_WIDTH-1:0] CntMax = '1;

  logic [PWM_WIDTH-1:0] count_d, count_q;
  logic                 bad_d, bad_q;
  logic                 prev_d, prev_q;

  always_comb begin
    count_d = count_q;
    bad_d   = bad_q;
    prev_d  = led;
    if (restart) begin
      count_d = {{(PWM_WIDTH-1){1'b0}}, led};
      bad_d   = 1'b0;
    end else if (led) begin
      // A legal line only falls after the period start; any rise is a glitch.
      if (!prev_q) begin
        bad_d = 1'b1;
      end
      // Reaching 2^W would mean high for the whole period: also illegal.
      if (count_q == CntMax) begin
        bad_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      bad_q   <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      bad_q   <= bad_d;
      prev_q  <= prev_d;
    end
  end

  assign count = count_q;
  assign bad   = bad_q;

endmodule

// File: rtl/rgb_pwm_capture.sv
// Recovers red/green/blue duty values from three PWM LED drive lines.
// Each period of 2^PWM_WIDTH cycles starts with a one-cycle sync pulse; the
// high-cycle count per channel is published once per clean period.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   sync                 : period-start pulse (ramp == 0)
//   redled/greenled/blueled : LED drive lines
//   red/green/blue       : last recovered values, updated only with valid
//   valid                : one-cycle pulse, values updated
//   locked               : tracking a well-formed period sequence
//   err, err_code        : one-cycle error pulse and its cause (held)
module rgb_pwm_capture
  import rgbpwm_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync,
  input  logic                 redled,
  input  logic                 greenled,
  input  logic                 blueled,
  output logic [PWM_WIDTH-1:0] red,
  output logic [PWM_WIDTH-1:0] green,
  output logic [PWM_WIDTH-1:0] blue,
  output logic                 valid,
  output logic                 locked,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam logic [PWM_WIDTH-1:0] PcntLast = '1;

  logic [PWM_WIDTH-1:0] red_cnt, green_cnt, blue_cnt;
  logic                 red_bad, green_bad, blue_bad;
  logic                 any_bad;
  logic                 restart;

  // Every sync starts a new count, whether it ends a period or (re)locks.
  assign restart = sync;
  assign any_bad = red_bad | green_bad | blue_bad;

  pwm_chan_meter #(.PWM_WIDTH(PWM_WIDTH)) u_red (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .led    (redled),
    .count  (red_cnt),
    .bad    (red_bad)
  );

  pwm_chan_meter #(.PWM_WIDTH(PWM_WIDTH)) u_green (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .led    (greenled),
    .count  (green_cnt),
    .bad    (green_bad)
  );

  pwm_chan_meter #(.PWM_WIDTH(PWM_WIDTH)) u_blue (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .led    (blueled),
    .count  (blue_cnt),
    .bad    (blue_bad)
  );

  state_e               state_d, state_q;
  logic [PWM_WIDTH-1:0] pcnt_d, pcnt_q;
  logic [PWM_WIDTH-1:0] red_d, red_q, green_d, green_q, blue_d, blue_q;
  logic                 valid_d, valid_q;
  logic                 err_d, err_q;
  logic [1:0]           err_code_d, err_code_q;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      UNLOCKED: begin
        if (sync) begin
          state_d = RUN;
          pcnt_d  = '0;
        end
      end
      RUN: begin
        pcnt_d = pcnt_q + 1'b1;
        if (sync) begin
          pcnt_d = '0;
          if (pcnt_q == PcntLast) begin
            if (any_bad) begin
              err_d      = 1'b1;
              err_code_d = ERR_MALFORMED;
            end else begin
              valid_d = 1'b1;
              red_d   = red_cnt;
              green_d = green_cnt;
              blue_d  = blue_cnt;
            end
          end else begin
            // Early sync: counts are meaningless, restart as a fresh period.
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
          end
        end else if (pcnt_q == PcntLast) begin
          // Missing sync outranks a pending malformed flag.
          err_d      = 1'b1;
          err_code_d = ERR_MISSING;
          state_d    = UNLOCKED;
          pcnt_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      pcnt_q     <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign locked   = (state_q == RUN);

endmodule

// File: doc/rgb_pwm_capture.md
# rgb_pwm_capture

Receive-side counterpart of the RGB PWM comparator: recovers the red/green/blue duty values from the three serial LED drive lines. Each line carries `value > pwm` against a free-running `PWM_WIDTH`-bit ramp; the block counts high cycles per channel over each PWM period and publishes the three values once per period. Used in loopback self-test of the panel driver and for monitoring the drive lines on the board.

## Interface
- `PWM_WIDTH`, 12, width of the PWM ramp and of each recovered value; period is 2^PWM_WIDTH cycles
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `sync`  in  1  one-cycle pulse in the cycle where the ramp equals 0 (period start)
- `redled`, `greenled`, `blueled`  in  1 each  LED drive lines, synchronous to `clk`
- `red`, `green`, `blue`  out  PWM_WIDTH each  last recovered values; held between updates
- `valid`  out  1  one-cycle pulse: `red`/`green`/`blue` updated this cycle
- `locked`  out  1  high while tracking a well-formed period sequence
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  cause, qualified by `err`: 1 short period, 2 missing sync, 3 malformed waveform

## Operation
- FSM states: UNLOCKED, RUN.
- UNLOCKED: wait for `sync`. On `sync`, enter RUN, clear the period counter, and start the channel counts with this cycle's LED samples.
- RUN: period counter `pcnt` (PWM_WIDTH bits) increments every cycle. Each channel counter adds 1 for each high sample.
- Expected `sync`: `sync` high with `pcnt` == 2^W−1, i.e. exactly 2^W cycles after the previous `sync`. Captures the three counts, pulses `valid` if the period was clean, and restarts all counters. The `sync` cycle's LED sample counts toward the new period.
- Short period: `sync` high with `pcnt` != 2^W−1. Discard the counts, no `valid`, pulse `err` with code 1, restart as a fresh period. Stays in RUN.
- Missing sync: `pcnt` == 2^W−1 and `sync` low. Pulse `err` with code 2, go to UNLOCKED. `locked` drops.
- Malformed waveform: a legal line is high only in a contiguous run starting at `sync`. Any 0→1 transition after the first cycle of a period, on any channel, marks the period bad.
  - At the next expected `sync`: no `valid`; pulse `err` with code 3.
  - An all-high period (count would reach 2^W) is also malformed. Counters saturate at 2^W−1.
- Simultaneous conditions: missing sync takes precedence. Short period discards any pending malformed flag.
- `locked` = state is RUN.

## Timing
- Reset (`rst_n` low at an edge): state UNLOCKED; `red`, `green`, `blue` = 0; `valid`, `err`, `locked` = 0; `err_code` = 0; all counters cleared.
- Reset mid-period abandons the period. The next period is valid no earlier than one full period after the first post-reset `sync`.
- Latency: `valid`, the updated values, and `err` are registered and appear the cycle after the terminating `sync` (or after the missing-sync cycle).
- `red`/`green`/`blue` change only in cycles with `valid`=1.
- `err_code` holds its last value; it is meaningful only with `err`.
- Value 0 is a line low for the whole period. Max value 2^W−1 is high for all but the last cycle.

## Structure
- Package `rgbpwm_pkg`:
  - FSM state enum {UNLOCKED, RUN}
  - error-code constants ERR_NONE=0, ERR_SHORT=1, ERR_MISSING=2, ERR_MALFORMED=3
- Sub-module `pwm_chan_meter`, instantiated three times:
  - saturating high-cycle counter
  - previous-sample register
  - sticky malformed flag
  - inputs: `clk`, `rst_n`, `restart`, `led`; outputs: `count`, `bad`
- Top level holds the FSM, `pcnt`, output registers, and error priority.

## Test plan
(`PWM_WIDTH`=4, period 16.)
- Reset, then `sync` every 16 cycles with red high 5 cycles, green 0, blue 15 → after the second `sync`: `valid` for 1 cycle, red=5, green=0, blue=15, `locked`=1, `err`=0.
- Green high, low, high within one period → no `valid` at the period end; `err`=1 with `err_code`=3; the following clean period publishes normally.
- `sync` 10 cycles after the previous one → `err`, code 1, no `valid`; the next 16-cycle period gives `valid` with correct values.
- `sync` withheld after a period → `err`, code 2, one cycle after `pcnt`=15; `locked`=0; outputs hold the last values; relock on the next `sync`.
- Red held high for a full period → code 3, red output unchanged.
- Assert `rst_n` low for 1 cycle mid-period → all outputs 0; no `valid` until a full period after the next `sync`.
